// File: rtl/data_pkg.sv
// -----------------------------------------------------------------------------
// data_pkg
// Shared helpers for the data_packer serial-to-parallel packer.
//   clog2    : ceiling log2, usable in constant (elaboration) context
//   RATIO    : beats per word for the default 2-bit -> 8-bit configuration
//   CNT_W    : beat-counter width for the default configuration
//   LANES_W  : width of the lane-count output for the default configuration
//   lane_lo  : low bit index of lane idx inside the output word
// Modules with non-default widths derive their own constants with the same
// functions, so the default-valued constants here serve as a reference point.
// -----------------------------------------------------------------------------
package data_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int DEF_IN_W  = 2;
    localparam int DEF_OUT_W = 8;
    localparam int RATIO     = DEF_OUT_W / DEF_IN_W;
    localparam int CNT_W     = clog2(RATIO);
    localparam int LANES_W   = CNT_W + 1;

    // MSB-first puts beat 0 in the top lane; LSB-first puts it in the bottom.
    function automatic int lane_lo(input int idx, input bit msb_first,
                                   input int in_w, input int out_w);
        if (msb_first) begin
            return out_w - in_w * (idx + 1);
        end
        return in_w * idx;
    endfunction

endpackage

// File: rtl/data_packer.sv
// -----------------------------------------------------------------------------
// data_packer
// Collects OUT_W/IN_W narrow input beats into one output word, with
// valid/ready flow control on both sides, selectable lane order, early
// flush of a partial word on din_last, and a selectable idle-gap policy.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   din        : input beat (IN_W bits)
//   din_en     : input beat valid
//   din_last   : beat closes the current word (qualified by din_en)
//   din_rdy    : packer accepts a beat this cycle (combinational)
//   dout       : packed word, unused lanes are 0
//   dout_en    : output word valid
//   dout_rdy   : consumer accepts the word
//   dout_lanes : number of valid beats in dout (1..RATIO), 0 after reset
// -----------------------------------------------------------------------------
module data_packer
    import data_pkg::*;
#(
    parameter int IN_W        = 2,
    parameter int OUT_W       = 8,
    parameter bit MSB_FIRST   = 1'b1,
    parameter bit GAP_DISCARD = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [IN_W-1:0]                  din,
    input  logic                             din_en,
    input  logic                             din_last,
    output logic                             din_rdy,
    output logic [OUT_W-1:0]                 dout,
    output logic                             dout_en,
    input  logic                             dout_rdy,
    output logic [clog2(OUT_W/IN_W):0]       dout_lanes
);

    localparam int N_LANES   = OUT_W / IN_W;
    localparam int CNT_BITS  = (clog2(N_LANES) < 1) ? 1 : clog2(N_LANES);
    localparam int LANE_BITS = clog2(N_LANES) + 1;

    generate
        if ((OUT_W % IN_W) != 0 || N_LANES < 2) begin : g_bad_params
            $error("data_packer: OUT_W must be a multiple of IN_W with OUT_W/IN_W >= 2");
        end
    endgenerate

    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]     acc_q, acc_d;
    logic [OUT_W-1:0]     dout_q, dout_d;
    logic                 dout_en_q, dout_en_d;
    logic [LANE_BITS-1:0] lanes_q, lanes_d;

    logic                 accept;
    logic                 final_beat;
    logic [OUT_W-1:0]     merged;

    // Ready only looks at registered state and the consumer, never at din.
    assign din_rdy    = !dout_en_q || dout_rdy;
    assign accept     = din_en && din_rdy;
    assign final_beat = accept && ((cnt_q == CNT_BITS'(N_LANES - 1)) || din_last);

    // Accumulator with the current beat dropped into lane cnt_q.
    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            localparam int LO = lane_lo(gi, MSB_FIRST, IN_W, OUT_W);
            assign merged[LO +: IN_W] = (cnt_q == CNT_BITS'(gi)) ? din : acc_q[LO +: IN_W];
        end
    endgenerate

    // Accumulator and beat counter.
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (accept) begin
            if (final_beat) begin
                cnt_d = '0;
                acc_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_BITS'(1);
                acc_d = merged;
            end
        end else if (!din_en && GAP_DISCARD) begin
            // A true idle cycle; stalled cycles (din_en=1, din_rdy=0) keep state.
            cnt_d = '0;
            acc_d = '0;
        end
    end

    // Output register: a final beat in the same cycle as a drain replaces
    // the word without dropping dout_en.
    always_comb begin
        dout_d    = dout_q;
        dout_en_d = dout_en_q;
        lanes_d   = lanes_q;
        if (dout_en_q && dout_rdy) begin
            dout_en_d = 1'b0;
        end
        if (final_beat) begin
            dout_d    = merged;
            dout_en_d = 1'b1;
            lanes_d   = LANE_BITS'(cnt_q) + LANE_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            dout_q    <= '0;
            dout_en_q <= 1'b0;
            lanes_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            dout_q    <= dout_d;
            dout_en_q <= dout_en_d;
            lanes_q   <= lanes_d;
        end
    end

    assign dout       = dout_q;
    assign dout_en    = dout_en_q;
    assign dout_lanes = lanes_q;

endmodule

// File: tb/tb_data_packer.sv
// -----------------------------------------------------------------------------
// tb_data_packer
// Directed bench for data_packer. Three instances share one stimulus:
//   dut_a : defaults (MSB first, gaps discard)
//   dut_b : LSB first
//   dut_c : gaps hold the partial word
// -----------------------------------------------------------------------------
module tb_data_packer;

    logic       clk;
    logic       rst_n;
    logic [1:0] din;
    logic       din_en;
    logic       din_last;
    logic       dout_rdy;

    logic       rdy_a, rdy_b, rdy_c;
    logic [7:0] dout_a, dout_b, dout_c;
    logic       en_a, en_b, en_c;
    logic [2:0] lanes_a, lanes_b, lanes_c;

    int total_checks;
    int passed_checks;

    data_packer #(.IN_W(2), .OUT_W(8), .MSB_FIRST(1'b1), .GAP_DISCARD(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en), .din_last(din_last),
        .din_rdy(rdy_a), .dout(dout_a), .dout_en(en_a), .dout_rdy(dout_rdy),
        .dout_lanes(lanes_a)
    );

    data_packer #(.IN_W(2), .OUT_W(8), .MSB_FIRST(1'b0), .GAP_DISCARD(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en), .din_last(din_last),
        .din_rdy(rdy_b), .dout(dout_b), .dout_en(en_b), .dout_rdy(dout_rdy),
        .dout_lanes(lanes_b)
    );

    data_packer #(.IN_W(2), .OUT_W(8), .MSB_FIRST(1'b1), .GAP_DISCARD(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en), .din_last(din_last),
        .din_rdy(rdy_c), .dout(dout_c), .dout_en(en_c), .dout_rdy(dout_rdy),
        .dout_lanes(lanes_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) begin
            passed_checks++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] value, input logic last);
        din      = value;
        din_en   = 1'b1;
        din_last = last;
        tick();
    endtask

    task automatic idle();
        din_en   = 1'b0;
        din_last = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        din_en   = 1'b0;
        din_last = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n    = 1'b1;
        #1;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        rst_n    = 1'b0;
        din      = 2'd0;
        din_en   = 1'b0;
        din_last = 1'b0;
        dout_rdy = 1'b0;

        // Reset values
        #2;
        check("reset_dout", 32'(dout_a), 32'h00);
        check("reset_dout_en", 32'(en_a), 32'h0);
        check("reset_lanes", 32'(lanes_a), 32'h0);
        check("reset_din_rdy", 32'(rdy_a), 32'h1);
        tick();
        rst_n = 1'b1;
        #1;
        $display("txn reset released");

        // Full word 3,2,1,0
        dout_rdy = 1'b1;
        beat(2'd3, 1'b0);
        beat(2'd2, 1'b0);
        beat(2'd1, 1'b0);
        check("w1_no_early_en", 32'(en_a), 32'h0);
        beat(2'd0, 1'b0);
        check("w1_msb_dout", 32'(dout_a), 32'hE4);
        check("w1_msb_en", 32'(en_a), 32'h1);
        check("w1_msb_lanes", 32'(lanes_a), 32'h4);
        check("w1_lsb_dout", 32'(dout_b), 32'h1B);
        check("w1_lsb_lanes", 32'(lanes_b), 32'h4);
        $display("txn word msb=%02h lsb=%02h lanes=%0d", dout_a, dout_b, lanes_a);
        idle();
        check("w1_drain_en", 32'(en_a), 32'h0);
        check("w1_drain_dout_kept", 32'(dout_a), 32'hE4);

        // Partial flush: 3,1 with din_last, then a one-lane word
        beat(2'd3, 1'b0);
        beat(2'd1, 1'b1);
        check("flush_dout", 32'(dout_a), 32'hD0);
        check("flush_lanes", 32'(lanes_a), 32'h2);
        check("flush_lsb_dout", 32'(dout_b), 32'h07);
        $display("txn flush dout=%02h lanes=%0d", dout_a, lanes_a);
        beat(2'd2, 1'b1);
        check("one_lane_dout", 32'(dout_a), 32'h80);
        check("one_lane_lanes", 32'(lanes_a), 32'h1);
        check("one_lane_en_no_bubble", 32'(en_a), 32'h1);
        $display("txn one-lane dout=%02h lanes=%0d", dout_a, lanes_a);
        idle();
        check("one_lane_drain_en", 32'(en_a), 32'h0);

        // Gap policy: 1,1, idle, 2,2,2,2
        do_reset();
        beat(2'd1, 1'b0);
        beat(2'd1, 1'b0);
        idle();
        beat(2'd2, 1'b0);
        beat(2'd2, 1'b0);
        check("gap_hold_dout", 32'(dout_c), 32'h5A);
        check("gap_hold_en", 32'(en_c), 32'h1);
        check("gap_discard_no_word", 32'(en_a), 32'h0);
        $display("txn gap-hold dout=%02h", dout_c);
        beat(2'd2, 1'b0);
        beat(2'd2, 1'b0);
        check("gap_discard_dout", 32'(dout_a), 32'hAA);
        check("gap_discard_en", 32'(en_a), 32'h1);
        check("gap_hold_drained", 32'(en_c), 32'h0);
        $display("txn gap-discard dout=%02h", dout_a);
        // The held partial 2,2 must survive another idle cycle.
        idle();
        beat(2'd0, 1'b0);
        beat(2'd0, 1'b0);
        check("gap_hold_partial_dout", 32'(dout_c), 32'hA0);
        check("gap_hold_partial_en", 32'(en_c), 32'h1);
        check("gap_discard_partial_no_word", 32'(en_a), 32'h0);
        $display("txn gap-hold partial dout=%02h", dout_c);

        // Back-pressure
        do_reset();
        dout_rdy = 1'b1;
        beat(2'd3, 1'b0);
        beat(2'd2, 1'b0);
        beat(2'd1, 1'b0);
        beat(2'd0, 1'b0);
        dout_rdy = 1'b0;
        din      = 2'd0;
        din_en   = 1'b1;
        #1;
        check("bp_din_rdy_low", 32'(rdy_a), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_dout", 32'(dout_a), 32'hE4);
            check("bp_hold_en", 32'(en_a), 32'h1);
            check("bp_hold_lanes", 32'(lanes_a), 32'h4);
            check("bp_rdy_low", 32'(rdy_a), 32'h0);
            $display("txn stall %0d dout=%02h din_rdy=%0b", i, dout_a, rdy_a);
        end
        dout_rdy = 1'b1;
        beat(2'd0, 1'b0);
        check("bp_release_drain", 32'(en_a), 32'h0);
        beat(2'd1, 1'b0);
        beat(2'd2, 1'b0);
        beat(2'd3, 1'b0);
        check("bp_second_dout", 32'(dout_a), 32'h1B);
        check("bp_second_en", 32'(en_a), 32'h1);
        check("bp_second_lanes", 32'(lanes_a), 32'h4);
        $display("txn after-stall dout=%02h", dout_a);

        // Reset while a word is stalled
        dout_rdy = 1'b0;
        idle();
        check("rst_stall_pre_en", 32'(en_a), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_stall_en", 32'(en_a), 32'h0);
        check("rst_stall_dout", 32'(dout_a), 32'h00);
        check("rst_stall_lanes", 32'(lanes_a), 32'h0);
        check("rst_stall_din_rdy", 32'(rdy_a), 32'h1);
        $display("txn async reset during stall");
        #2;
        rst_n = 1'b1;
        tick();

        // Reset mid-word after 2 accepted beats
        dout_rdy = 1'b1;
        beat(2'd3, 1'b0);
        beat(2'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_midword_en", 32'(en_a), 32'h0);
        #2;
        rst_n = 1'b1;
        #1;
        beat(2'd0, 1'b0);
        beat(2'd1, 1'b0);
        check("rst_midword_no_early", 32'(en_a), 32'h0);
        beat(2'd2, 1'b0);
        beat(2'd3, 1'b0);
        check("rst_fresh_dout", 32'(dout_a), 32'h1B);
        check("rst_fresh_en", 32'(en_a), 32'h1);
        check("rst_fresh_lanes", 32'(lanes_a), 32'h4);
        $display("txn post-reset dout=%02h lanes=%0d", dout_a, lanes_a);
        idle();

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
